bidir_memory: RTL and testbench



---
 rtl/bidir_memory.sv | 32 +++
 tb/tb_bidir_memory.sv | 133 +++++++++++++
 2 files changed

// File: rtl/bidir_memory.sv
// Scratch RAM on a shared bidirectional bus: synchronous write, combinational read.
// The driver is enabled only for a pure read, so a write always owns the bus.
module bidir_memory #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic              rd,
  input  logic [AWIDTH-1:0] addr,
  inout  wire  [DWIDTH-1:0] data
);

  localparam int DEPTH = 1 << AWIDTH;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic              drive;

  // Whole array clears asynchronously; a write on a coincident edge is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr) begin
      mem[addr] <= data;
    end
  end

  assign drive = rd && !wr;
  assign data  = drive ? mem[addr] : {DWIDTH{1'bz}};

endmodule

// File: tb/tb_bidir_memory.sv
// Directed bench for bidir_memory: table of write/read vectors plus hand sequences
// for reset, bus release, write/read overlap and back-to-back writes.
module tb_bidir_memory;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic [4:0] addr = '0;
  logic [7:0] drv = '0;
  logic       drv_en = 1'b0;
  wire  [7:0] data;

  int n_cmp = 0;
  int n_fail = 0;

  assign data = drv_en ? drv : 8'bz;

  bidir_memory #(.AWIDTH(5), .DWIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd), .addr(addr), .data(data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       is_wr;
    logic [4:0] a;
    logic [7:0] d;
    string      name;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; drv = d; drv_en = 1'b1; rd = 1'b0; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0; drv_en = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a, input logic [7:0] exp, input string name);
    @(negedge clk);
    addr = a; drv_en = 1'b0; wr = 1'b0; rd = 1'b1;
    @(negedge clk);
    check(name, data, exp);
    rd = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd0,  8'hFF, "wr0"};
    vecs[1] = '{1'b1, 5'd31, 8'h00, "wr31"};
    vecs[2] = '{1'b0, 5'd0,  8'hFF, "rd_addr0"};
    vecs[3] = '{1'b0, 5'd31, 8'h00, "rd_addr31"};
    vecs[4] = '{1'b1, 5'd31, 8'h00, "wr31b"};
    vecs[5] = '{1'b0, 5'd31, 8'h00, "rd_addr31b"};

    // Reset state: memory reads 0 while reset is held
    #12;
    rd = 1'b1; addr = 5'd4;
    #1 check("reset_rd_addr4", data, 8'h00);
    rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].is_wr) do_write(vecs[i].a, vecs[i].d);
      else do_read(vecs[i].a, vecs[i].d, vecs[i].name);
    end

    // Descending fill: addr 31-k gets k
    for (int k = 0; k <= 30; k++) do_write(5'(31 - k), 8'(k));
    for (int k = 0; k <= 30; k++) do_read(5'(31 - k), 8'(k), $sformatf("fill_addr%0d", 31 - k));
    do_read(5'd0, 8'hFF, "fill_addr0_kept");

    // Asynchronous reset between edges, checked before any clock edge
    @(posedge clk);
    #2 rst_n = 1'b0;
    rd = 1'b1; addr = 5'd0;
    #1 check("async_rst_addr0", data, 8'h00);
    addr = 5'd1;
    #0.5 check("async_rst_addr1", data, 8'h00);
    addr = 5'd31;
    #0.5 check("async_rst_addr31", data, 8'h00);
    rd = 1'b0;
    // Write attempted while reset held is ignored
    @(negedge clk);
    addr = 5'd3; drv = 8'h77; drv_en = 1'b1; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0; drv_en = 1'b0;
    rst_n = 1'b1;
    do_read(5'd3, 8'h00, "wr_during_rst");

    // Driver gating: master overlays a value that differs from stored word
    do_write(5'd7, 8'hF0);
    @(negedge clk);
    addr = 5'd7; rd = 1'b0; drv = 8'h0F; drv_en = 1'b1;
    #1 check("rd0_not_driven", data, 8'h0F);
    drv_en = 1'b0; rd = 1'b1;
    #1 check("rd1_same_cycle", data, 8'hF0);
    rd = 1'b0; drv_en = 1'b1;
    #1 check("rd_fall_released", data, 8'h0F);
    drv_en = 1'b0;

    // wr and rd both high: write wins, memory stays off the bus
    do_write(5'd5, 8'h5A);
    @(negedge clk);
    addr = 5'd5; drv = 8'hA5; drv_en = 1'b1; wr = 1'b1; rd = 1'b1;
    #1 check("wr_rd_no_drive", data, 8'hA5);
    @(negedge clk);
    wr = 1'b0; rd = 1'b0; drv_en = 1'b0;
    do_read(5'd5, 8'hA5, "wr_rd_result");

    // Back-to-back writes to the same address
    @(negedge clk);
    addr = 5'd9; drv = 8'h11; drv_en = 1'b1; wr = 1'b1;
    @(negedge clk);
    drv = 8'h22;
    @(negedge clk);
    wr = 1'b0; drv_en = 1'b0;
    do_read(5'd9, 8'h22, "b2b_write");
    do_read(5'd9, 8'h22, "nondestructive");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
